// File: rtl/sand_cell_diag_if.sv
// Bundles the scheduler handshake and frame-buffer RAM port of the sand
// cell engine. The engine side uses the slave modport, its environment
// (scheduler plus RAM) uses the master modport.
//
// Handshake: ready_i is a request strobe sampled only while the engine is
// idle, and base_address_i/col_i/row_i are captured in the same cycle.
// ready_i is ignored while busy_o is high. Every accepted request ends with
// exactly one done_o pulse, and moved_o is high in that cycle only when the
// cell moved. wr_ena_o qualifies write_address_o/write_data_o, which read
// zero otherwise. pixel_state_i is the RAM data for read_address_o. That
// register serves as the RAM's address register, so its data is usable in
// the following state.
interface sand_cell_diag_if #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int COL_WIDTH      = $clog2(ACTIVE_COLUMNS),
  parameter int ROW_WIDTH      = $clog2(ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2
);
  logic                  ready_i;
  logic [ADDR_WIDTH-1:0] base_address_i;
  logic [COL_WIDTH-1:0]  col_i;
  logic [ROW_WIDTH-1:0]  row_i;
  logic [DATA_WIDTH-1:0] pixel_state_i;
  logic [ADDR_WIDTH-1:0] read_address_o;
  logic [ADDR_WIDTH-1:0] write_address_o;
  logic [DATA_WIDTH-1:0] write_data_o;
  logic                  wr_ena_o;
  logic                  busy_o;
  logic                  moved_o;
  logic                  done_o;
  logic [2:0]            state_dbg;

  modport slave (
    input  ready_i, base_address_i, col_i, row_i, pixel_state_i,
    output read_address_o, write_address_o, write_data_o, wr_ena_o,
           busy_o, moved_o, done_o, state_dbg
  );

  modport master (
    output ready_i, base_address_i, col_i, row_i, pixel_state_i,
    input  read_address_o, write_address_o, write_data_o, wr_ena_o,
           busy_o, moved_o, done_o, state_dbg
  );
endinterface

// File: rtl/sand_cell_diag.sv
// Falling-sand per-cell update engine. It reads one cell and, if it is sand,
// moves it straight down, else diagonally down (alternating left/right
// preference per request), else leaves it in place. The state is visible
// on bus.state_dbg.
module sand_cell_diag #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int COL_WIDTH      = $clog2(ACTIVE_COLUMNS),
  parameter int ROW_WIDTH      = $clog2(ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2,
  parameter int EMPTY_CODE     = 0,
  parameter int SAND_CODE      = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  sand_cell_diag_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] COLS_A   = ADDR_WIDTH'(ACTIVE_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0]  LAST_COL = COL_WIDTH'(ACTIVE_COLUMNS - 1);
  localparam logic [ROW_WIDTH-1:0]  LAST_ROW = ROW_WIDTH'(ACTIVE_ROWS - 1);
  localparam logic [DATA_WIDTH-1:0] EMPTY_D  = DATA_WIDTH'(EMPTY_CODE);
  localparam logic [DATA_WIDTH-1:0] SAND_D   = DATA_WIDTH'(SAND_CODE);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    CHECK_SELF   = 3'd1,
    CHECK_DOWN   = 3'd2,
    CHECK_DIAG_A = 3'd3,
    CHECK_DIAG_B = 3'd4,
    WRITE_DEST   = 3'd5,
    CLEAR_SRC    = 3'd6
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base_q, rd_addr, rd_addr_next;
  logic [ADDR_WIDTH-1:0] dest, dest_next, diag_b, diag_b_next;
  logic                  diag_b_ok, diag_b_ok_next;
  logic [COL_WIDTH-1:0]  col_q;
  logic [ROW_WIDTH-1:0]  row_q;
  logic                  dir_q;
  logic                  load_req;
  logic                  done, moved, wr_ena;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Diagonal candidates. Edge columns drop the side that would wrap into
  // the neighbouring row. dir_q picks which side is tried first.
  logic                  left_ok, right_ok, first_ok, second_ok;
  logic [ADDR_WIDTH-1:0] left_addr, right_addr, first_addr, second_addr;

  assign left_ok     = (col_q != '0);
  assign right_ok    = (col_q != LAST_COL);
  assign left_addr   = base_q + COLS_A - ONE_A;
  assign right_addr  = base_q + COLS_A + ONE_A;
  assign first_ok    = left_ok | right_ok;
  assign second_ok   = left_ok & right_ok;
  assign first_addr  = (dir_q == 1'b0) ? (left_ok ? left_addr : right_addr)
                                       : (right_ok ? right_addr : left_addr);
  assign second_addr = (dir_q == 1'b0) ? right_addr : left_addr;

  // Next-state and output decode.
  always_comb begin
    state_next     = state;
    rd_addr_next   = rd_addr;
    dest_next      = dest;
    diag_b_next    = diag_b;
    diag_b_ok_next = diag_b_ok;
    load_req       = 1'b0;
    done           = 1'b0;
    moved          = 1'b0;
    wr_ena         = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    case (state)
      IDLE: begin
        if (bus.ready_i) begin
          load_req     = 1'b1;
          rd_addr_next = bus.base_address_i;
          state_next   = CHECK_SELF;
        end
      end
      CHECK_SELF: begin
        if (bus.pixel_state_i != SAND_D || row_q == LAST_ROW) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          rd_addr_next = base_q + COLS_A;
          state_next   = CHECK_DOWN;
        end
      end
      CHECK_DOWN: begin
        if (bus.pixel_state_i == EMPTY_D) begin
          dest_next  = rd_addr;
          state_next = WRITE_DEST;
        end else if (first_ok) begin
          rd_addr_next   = first_addr;
          diag_b_next    = second_addr;
          diag_b_ok_next = second_ok;
          state_next     = CHECK_DIAG_A;
        end else begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      CHECK_DIAG_A: begin
        if (bus.pixel_state_i == EMPTY_D) begin
          dest_next  = rd_addr;
          state_next = WRITE_DEST;
        end else if (diag_b_ok) begin
          rd_addr_next = diag_b;
          state_next   = CHECK_DIAG_B;
        end else begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      CHECK_DIAG_B: begin
        if (bus.pixel_state_i == EMPTY_D) begin
          dest_next  = rd_addr;
          state_next = WRITE_DEST;
        end else begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE_DEST: begin
        wr_ena     = 1'b1;
        wr_addr    = dest;
        wr_data    = SAND_D;
        state_next = CLEAR_SRC;
      end
      CLEAR_SRC: begin
        wr_ena     = 1'b1;
        wr_addr    = base_q;
        wr_data    = EMPTY_D;
        done       = 1'b1;
        moved      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, captured request and address registers; preference flips per done.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      base_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      rd_addr   <= '0;
      dest      <= '0;
      diag_b    <= '0;
      diag_b_ok <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state     <= state_next;
      rd_addr   <= rd_addr_next;
      dest      <= dest_next;
      diag_b    <= diag_b_next;
      diag_b_ok <= diag_b_ok_next;
      if (load_req) begin
        base_q <= bus.base_address_i;
        col_q  <= bus.col_i;
        row_q  <= bus.row_i;
      end
      if (done) begin
        dir_q <= ~dir_q;
      end
    end
  end

  assign bus.read_address_o  = rd_addr;
  assign bus.write_address_o = wr_addr;
  assign bus.write_data_o    = wr_data;
  assign bus.wr_ena_o        = wr_ena;
  assign bus.busy_o          = (state != IDLE);
  assign bus.moved_o         = moved;
  assign bus.done_o          = done;
  assign bus.state_dbg       = state;

endmodule

// File: tb/tb_sand_cell_diag.sv
// Directed bench for sand_cell_diag: a behavioural frame-buffer RAM, a write
// scoreboard fed from exp_q, and a linear sequence of request scenarios.
module tb_sand_cell_diag;
  localparam int COLS  = 640;
  localparam int ROWS  = 480;
  localparam int AW    = 19;
  localparam int CW    = 10;
  localparam int RW    = 9;
  localparam int DW    = 2;
  localparam int FRAME = COLS * ROWS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [AW+DW-1:0] exp_q[$];

  logic [DW-1:0] mem [0:FRAME-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;

  sand_cell_diag_if bus ();

  sand_cell_diag dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus.slave)
  );

  // Clock and reset-time frame clear.
  always #5 clk = ~clk;

  assign bus.pixel_state_i = (bus.read_address_o < AW'(FRAME)) ? mem[bus.read_address_o] : 2'bxx;

  // Frame-buffer RAM: cleared while in reset, written by bench pokes or the DUT.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FRAME; i++) mem[i] <= '0;
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      if (bus.wr_ena_o && bus.write_address_o < AW'(FRAME))
        mem[bus.write_address_o] <= bus.write_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Write scoreboard: each DUT write must match the head of exp_q; idle write bus reads zero.
  always @(negedge clk) begin
    logic [AW+DW-1:0] got;
    logic [AW+DW-1:0] want;
    if (bus.wr_ena_o) begin
      got = {bus.write_address_o, bus.write_data_o};
      if (exp_q.size() == 0) want = '1;
      else want = exp_q.pop_front();
      chk("ram_write", 32'(got), 32'(want));
    end else if (reset_n) begin
      chk("idle_write_bus", 32'({bus.write_address_o, bus.write_data_o}), 32'd0);
    end
  end

  task automatic poke(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic expect_write(input int a, input logic [DW-1:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_rd_addr"}, 32'(bus.read_address_o), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.write_address_o), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.write_data_o), 32'd0);
    chk({tag, "_wr_ena"}, 32'(bus.wr_ena_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_moved"}, 32'(bus.moved_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_state"}, 32'(bus.state_dbg), 32'd0);
  endtask

  // One request: latency to done, moved flag, pulse width, drained writes,
  // and that a forbidden read address never appears.
  task automatic do_req(input string tag, input int a, input int c, input int r,
                        input int exp_lat, input logic exp_mv, input int watch);
    int   lat;
    logic mv;
    logic hit;
    lat = 0; mv = 1'b0; hit = 1'b0;
    @(negedge clk);
    bus.ready_i = 1'b1; bus.base_address_i = AW'(a);
    bus.col_i = CW'(c); bus.row_i = RW'(r);
    @(posedge clk);
    #1 bus.ready_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy_o && bus.read_address_o == AW'(watch)) hit = 1'b1;
      if (bus.done_o) begin
        lat = k; mv = bus.moved_o;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_moved"}, 32'(mv), 32'(exp_mv));
    chk({tag, "_forbidden_read"}, 32'(hit), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_busy_clear"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int dones;
    int busy_miss;
    int done_cycle;
    bus.ready_i = 1'b0;
    bus.base_address_i = '0;
    bus.col_i = '0;
    bus.row_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;

    // Reset asserted while in CHECK_DOWN: everything returns to zero at once
    poke(3210, 2'd1);
    @(negedge clk);
    bus.ready_i = 1'b1; bus.base_address_i = AW'(3210); bus.col_i = CW'(10); bus.row_i = RW'(5);
    @(posedge clk);
    #1 bus.ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_op_state", 32'(bus.state_dbg), 32'd2);
    reset_n = 1'b0;
    #1;
    check_quiet("mid_op_reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Empty cell: done in cycle 1, no move, no write
    do_req("empty_cell", 100, 100, 0, 1, 1'b0, -1);

    // Straight fall from (5,10)
    poke(3210, 2'd1);
    expect_write(3850, 2'd1); expect_write(3210, 2'd0);
    do_req("straight_fall", 3210, 10, 5, 4, 1'b1, -1);

    // Below static, both diagonals empty: left first, then right
    poke(3210, 2'd1); poke(3850, 2'd2);
    expect_write(3849, 2'd1); expect_write(3210, 2'd0);
    do_req("diag_left", 3210, 10, 5, 5, 1'b1, -1);
    poke(3210, 2'd1); poke(3849, 2'd0);
    expect_write(3851, 2'd1); expect_write(3210, 2'd0);
    do_req("diag_right", 3210, 10, 5, 5, 1'b1, -1);

    // Left preferred but held by static code 3: second diagonal taken
    poke(3210, 2'd1); poke(3849, 2'd3); poke(3851, 2'd0);
    expect_write(3851, 2'd1); expect_write(3210, 2'd0);
    do_req("diag_second", 3210, 10, 5, 6, 1'b1, -1);

    // All three targets full
    poke(3210, 2'd1);
    do_req("all_blocked", 3210, 10, 5, 4, 1'b0, -1);

    // Column 0: only the right diagonal exists; left would read base+639
    poke(3200, 2'd1); poke(3840, 2'd2); poke(3841, 2'd1);
    do_req("col0_blocked", 3200, 0, 5, 3, 1'b0, 3839);
    poke(3841, 2'd0);
    expect_write(3841, 2'd1); expect_write(3200, 2'd0);
    do_req("col0_right", 3200, 0, 5, 5, 1'b1, 3839);

    // Column 639: never addresses base+641, under either preference
    poke(3839, 2'd1); poke(4479, 2'd2); poke(4478, 2'd3);
    do_req("col639_a", 3839, 639, 5, 3, 1'b0, 4480);
    do_req("col639_b", 3839, 639, 5, 3, 1'b0, 4480);

    // Bottom row: done in cycle 1, row 480 never read
    poke(306565, 2'd1);
    do_req("bottom_row", 306565, 5, 479, 1, 1'b0, 307205);

    // ready_i held high while busy, then accepted right after done
    poke(3210, 2'd1); poke(3850, 2'd0);
    expect_write(3850, 2'd1); expect_write(3210, 2'd0);
    dones = 0; busy_miss = 0; done_cycle = 0;
    @(negedge clk);
    bus.ready_i = 1'b1; bus.base_address_i = AW'(3210); bus.col_i = CW'(10); bus.row_i = RW'(5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (!bus.busy_o) busy_miss++;
      if (bus.done_o) begin
        dones++; done_cycle = k;
      end
    end
    chk("held_ready_dones", 32'(dones), 32'd1);
    chk("held_ready_done_cycle", 32'(done_cycle), 32'd4);
    chk("held_ready_busy", 32'(busy_miss), 32'd0);
    @(negedge clk);
    chk("held_ready_idle_gap", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1 bus.ready_i = 1'b0;
    @(negedge clk);
    chk("back_to_back_done", 32'(bus.done_o), 32'd1);
    chk("back_to_back_moved", 32'(bus.moved_o), 32'd0);
    @(negedge clk);
    chk("back_to_back_idle", 32'(bus.busy_o), 32'd0);
    chk("final_writes_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sand_cell_diag.md
# sand_cell_diag

Per-cell update engine for the falling-sand simulation, and the successor to the single-direction sand cell. Given one frame-buffer address from the frame scheduler, it reads the cell and applies the sand rule: move straight down, else diagonally down-left/down-right, else stay. Edge and bottom-row clipping and a material code wider than one bit are included. It sits between the frame scheduler (ready/done handshake) and the single-port frame-buffer RAM (synchronous read, one-cycle latency).

## Interface
- ACTIVE_COLUMNS, 640, frame width in cells
- ACTIVE_ROWS, 480, frame height in cells
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), frame-buffer address width
- COL_WIDTH, $clog2(ACTIVE_COLUMNS), column index width
- ROW_WIDTH, $clog2(ACTIVE_ROWS), row index width
- DATA_WIDTH, 2, material code width
- EMPTY_CODE, 0, code of an empty cell
- SAND_CODE, 1, code of a falling cell; every other non-empty code is static and never moves and never accepts sand
- clk_i  in  1  system clock, all state on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- ready_i  in  1  start request, sampled only in IDLE
- base_address_i  in  ADDR_WIDTH  address of cell to update, captured with ready_i
- col_i  in  COL_WIDTH  column of that cell, captured with ready_i
- row_i  in  ROW_WIDTH  row of that cell, captured with ready_i
- pixel_state_i  in  DATA_WIDTH  RAM read data for the address presented the previous cycle
- read_address_o  out  ADDR_WIDTH  registered RAM read address
- write_address_o  out  ADDR_WIDTH  RAM write address, valid with wr_ena_o
- write_data_o  out  DATA_WIDTH  RAM write data, valid with wr_ena_o
- wr_ena_o  out  1  RAM write strobe
- busy_o  out  1  high whenever state is not IDLE
- moved_o  out  1  one-cycle pulse coincident with done_o when the cell moved
- done_o  out  1  one-cycle completion pulse, exactly one per accepted request

## Operation
- States: IDLE, CHECK_SELF, CHECK_DOWN, CHECK_DIAG_A, CHECK_DIAG_B, WRITE_DEST, CLEAR_SRC.
- IDLE: on ready_i, register base, col, row; read_address_o <= base; go to CHECK_SELF.
- CHECK_SELF: if pixel_state_i != SAND_CODE or row == ACTIVE_ROWS-1, pulse done_o and go to IDLE. Otherwise read_address_o <= base+ACTIVE_COLUMNS and go to CHECK_DOWN.
- CHECK_DOWN:
  - If pixel_state_i == EMPTY_CODE: dest <= base+ACTIVE_COLUMNS, go to WRITE_DEST.
  - Otherwise form the diagonal order from dir_reg: 0 means left first, 1 means right first. Left is valid only if col != 0; right is valid only if col != ACTIVE_COLUMNS-1.
  - Read the first valid diagonal (base+ACTIVE_COLUMNS-1 for left, +1 for right) and go to CHECK_DIAG_A, recording whether a second valid diagonal remains. If none is valid, pulse done_o and go to IDLE.
- CHECK_DIAG_A: if empty, dest <= that address and go to WRITE_DEST. Else, if the second diagonal is valid, read it and go to CHECK_DIAG_B. Else pulse done_o and go to IDLE.
- CHECK_DIAG_B: if empty, dest <= that address and go to WRITE_DEST. Else pulse done_o and go to IDLE.
- WRITE_DEST: wr_ena_o=1, write_address_o=dest, write_data_o=SAND_CODE; go to CLEAR_SRC.
- CLEAR_SRC: wr_ena_o=1, write_address_o=base, write_data_o=EMPTY_CODE, done_o=1, moved_o=1; go to IDLE.
- dir_reg toggles on every done_o, so the diagonal preference alternates request to request to avoid left bias.
- Address arithmetic is ADDR_WIDTH, unsigned. Edge and bottom-row checks guarantee no wrap, so results never leave the frame.
- ready_i outside IDLE is ignored; it is not queued.

## Timing
- Reset values: state IDLE, dir_reg 0, read_address_o 0. wr_ena_o, done_o, moved_o and busy_o are 0; write_address_o and write_data_o are 0.
- write_address_o and write_data_o read 0 whenever wr_ena_o=0.
- ready_i at cycle 0 gives the following latency to done_o:
  - Not sand, or bottom row: cycle 1.
  - Down move: cycle 4.
  - Blocked down, no valid diagonal: cycle 2.
  - First diagonal taken: cycle 5.
  - First diagonal blocked, no second: cycle 3.
  - Second diagonal taken: cycle 6.
  - All blocked: cycle 4.
- Back-to-back: the next ready_i is accepted in the cycle after done_o.
- Reset asserted mid-operation returns to IDLE immediately with no further writes. A pending CLEAR_SRC is dropped; the frame buffer is reinitialised on system reset.

## Test plan
- Reset, then static and empty: assert reset_ni low mid-CHECK_DOWN. All outputs go to 0 and state is IDLE. Then base=100 holding EMPTY_CODE: done_o at cycle 1, moved_o=0, no wr_ena_o.
- Straight fall: sand at (row 5, col 10) with below empty. Expect writes addr 3850 data 1, then addr 3210 data 0; done_o and moved_o at cycle 4.
- Diagonal alternation:
  - Sand at (5,10) with below full and both diagonals empty. First request writes 3849 (left); the identical second request writes 3851 (right).
  - Static neighbours (code 2/3) below and at 3849 must block.
- Edges: sand at col 0 with below full takes right or finishes in 3 cycles with no move. Sand at col 639 never addresses +641. Sand at row 479 gives done_o at cycle 1 with no read of row 480.
- Fully blocked and ignored ready: sand with all three targets full gives done_o at cycle 4, moved_o=0, zero writes. ready_i held high during busy_o starts no second operation until after done_o.
